// File: rtl/key_conditioner_if.sv
// key_conditioner_if
//   Groups the key inputs and conditioned event outputs of key_conditioner.
//   Signals:
//     inc_key_n, dec_key_n : raw active-low keys (0 = pressed), asynchronous
//     inc_pulse, dec_pulse : single-cycle increment / decrement events
//     inc_held,  dec_held  : debounced pressed level per key
//     conflict             : single-cycle flag, simultaneous events suppressed
//   Modports:
//     master : key source / event consumer (drives keys, reads events)
//     slave  : the conditioner itself (reads keys, drives events)
interface key_conditioner_if;
    logic inc_key_n;
    logic dec_key_n;
    logic inc_pulse;
    logic dec_pulse;
    logic inc_held;
    logic dec_held;
    logic conflict;

    modport master (
        output inc_key_n, dec_key_n,
        input  inc_pulse, dec_pulse, inc_held, dec_held, conflict
    );

    modport slave (
        input  inc_key_n, dec_key_n,
        output inc_pulse, dec_pulse, inc_held, dec_held, conflict
    );
endinterface

// File: rtl/key_conditioner.sv
// key_conditioner
//   Two-key (increment / decrement) conditioner: synchronizes each raw key,
//   debounces press and release, emits one event per accepted press plus
//   optional auto-repeat events while held, and suppresses events that occur
//   on both keys in the same cycle (flagged on conflict).
//   Ports:
//     clk   : clock, all logic on the rising edge
//     reset : synchronous, active-low reset
//     kif   : key_conditioner_if.slave (keys in, events / held levels out)
//   Parameters:
//     DEBOUNCE_CYCLES : stable synchronized samples to accept press/release
//     REPEAT_DELAY    : cycles from accepted press to first repeat event
//     REPEAT_PERIOD   : cycles between subsequent repeat events (>= 2)
//     REPEAT_EN       : 1 = auto-repeat, 0 = one event per press
module key_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000,
    parameter int unsigned REPEAT_EN       = 1
) (
    input logic               clk,
    input logic               reset,
    key_conditioner_if.slave  kif
);

    localparam int unsigned MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int unsigned MAX_P  = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
    localparam int unsigned CW     = $clog2(MAX_P + 1);

    localparam logic [CW-1:0] DEB_C    = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] DELAY_C  = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] PERIOD_C = CW'(REPEAT_PERIOD);
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS_WAIT,
        ST_HELD,
        ST_REPEAT,
        ST_RELEASE_WAIT
    } state_e;

    // Bit 0 = increment channel, bit 1 = decrement channel.
    logic [1:0] key_n;
    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] event_c;
    logic [1:0] held_d;

    logic inc_pulse_q;
    logic dec_pulse_q;
    logic inc_held_q;
    logic dec_held_q;
    logic conflict_q;

    assign key_n = {kif.dec_key_n, kif.inc_key_n};

    // Two-flop synchronizer; resets to the released level.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
        end
    end

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        state_e        state_q, state_d;
        logic [CW-1:0] stab_q, stab_d;
        logic [CW-1:0] rep_q, rep_d;
        logic [CW-1:0] stab_inc;
        logic [CW-1:0] rep_inc;
        logic          pressed;
        logic          ev;

        assign pressed  = ~sync2_q[ch];
        assign stab_inc = stab_q + ONE_C;
        assign rep_inc  = rep_q + ONE_C;

        always_ff @(posedge clk) begin
            if (!reset) begin
                state_q <= ST_IDLE;
                stab_q  <= '0;
                rep_q   <= '0;
            end else begin
                state_q <= state_d;
                stab_q  <= stab_d;
                rep_q   <= rep_d;
            end
        end

        // Debounce acceptance compares the stored count so the event lands
        // DEBOUNCE_CYCLES+2 edges after the pin is first sampled; repeat
        // timing compares the incremented count so events are exactly
        // REPEAT_DELAY / REPEAT_PERIOD edges apart.
        always_comb begin
            state_d = state_q;
            stab_d  = stab_q;
            rep_d   = rep_q;
            ev      = 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (pressed) begin
                        state_d = ST_PRESS_WAIT;
                        stab_d  = ONE_C;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!pressed) begin
                        state_d = ST_IDLE;
                        stab_d  = '0;
                    end else if (stab_q == DEB_C) begin
                        state_d = ST_HELD;
                        stab_d  = '0;
                        rep_d   = '0;
                        ev      = 1'b1;
                    end else begin
                        stab_d  = stab_inc;
                    end
                end
                ST_HELD: begin
                    if (!pressed) begin
                        state_d = ST_RELEASE_WAIT;
                        stab_d  = ONE_C;
                        rep_d   = '0;
                    end else if (REPEAT_EN != 0) begin
                        if (rep_inc == DELAY_C) begin
                            state_d = ST_REPEAT;
                            rep_d   = '0;
                            ev      = 1'b1;
                        end else begin
                            rep_d   = rep_inc;
                        end
                    end else if (rep_q != DELAY_C) begin
                        // Without repeat the count saturates at the delay.
                        rep_d = rep_inc;
                    end
                end
                ST_REPEAT: begin
                    if (!pressed) begin
                        state_d = ST_RELEASE_WAIT;
                        stab_d  = ONE_C;
                        rep_d   = '0;
                    end else if (rep_inc == PERIOD_C) begin
                        rep_d   = '0;
                        ev      = 1'b1;
                    end else begin
                        rep_d   = rep_inc;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (pressed) begin
                        state_d = ST_HELD;
                        stab_d  = '0;
                        rep_d   = '0;
                    end else if (stab_q == DEB_C) begin
                        state_d = ST_IDLE;
                        stab_d  = '0;
                    end else begin
                        stab_d  = stab_inc;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    stab_d  = '0;
                    rep_d   = '0;
                end
            endcase
        end

        assign event_c[ch] = ev;
        assign held_d[ch]  = (state_d == ST_HELD) || (state_d == ST_REPEAT) ||
                             (state_d == ST_RELEASE_WAIT);
    end

    // Output registers; simultaneous events cancel and raise conflict.
    always_ff @(posedge clk) begin
        if (!reset) begin
            inc_pulse_q <= 1'b0;
            dec_pulse_q <= 1'b0;
            inc_held_q  <= 1'b0;
            dec_held_q  <= 1'b0;
            conflict_q  <= 1'b0;
        end else begin
            inc_pulse_q <= event_c[0] & ~event_c[1];
            dec_pulse_q <= event_c[1] & ~event_c[0];
            inc_held_q  <= held_d[0];
            dec_held_q  <= held_d[1];
            conflict_q  <= event_c[0] & event_c[1];
        end
    end

    assign kif.inc_pulse = inc_pulse_q;
    assign kif.dec_pulse = dec_pulse_q;
    assign kif.inc_held  = inc_held_q;
    assign kif.dec_held  = dec_held_q;
    assign kif.conflict  = conflict_q;

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner
//   Directed bench for key_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
//   REPEAT_PERIOD=3. dut1 has auto-repeat enabled, dut2 has it disabled.
//   Observed vector per DUT: {inc_pulse, dec_pulse, inc_held, dec_held, conflict}.
//   "Edge 0" is the first clock edge that samples a newly driven key level.
module tb_key_conditioner;

    localparam logic [4:0] Z  = 5'b00000;
    localparam logic [4:0] PI = 5'b10000;
    localparam logic [4:0] PD = 5'b01000;
    localparam logic [4:0] HI = 5'b00100;
    localparam logic [4:0] HD = 5'b00010;
    localparam logic [4:0] CF = 5'b00001;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;

    key_conditioner_if if1 ();
    key_conditioner_if if2 ();

    key_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3),
        .REPEAT_EN      (1)
    ) dut1 (
        .clk  (clk),
        .reset(reset),
        .kif  (if1.slave)
    );

    key_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (10),
        .REPEAT_PERIOD  (3),
        .REPEAT_EN      (0)
    ) dut2 (
        .clk  (clk),
        .reset(reset),
        .kif  (if2.slave)
    );

    always #5 clk = ~clk;

    logic [4:0] obs1;
    logic [4:0] obs2;
    assign obs1 = {if1.inc_pulse, if1.dec_pulse, if1.inc_held, if1.dec_held, if1.conflict};
    assign obs2 = {if2.inc_pulse, if2.dec_pulse, if2.inc_held, if2.dec_held, if2.conflict};

    // Advance n edges; after each, compare both DUTs with their expected vectors.
    task automatic tick_n(input string tag, input int n, input logic [4:0] e1, input logic [4:0] e2);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            n_chk++;
            assert (obs1 === e1) else begin
                n_fail++;
                $error("FAIL %s dut1: observed=%b expected=%b", tag, obs1, e1);
            end
            n_chk++;
            assert (obs2 === e2) else begin
                n_fail++;
                $error("FAIL %s dut2: observed=%b expected=%b", tag, obs2, e2);
            end
        end
    endtask

    // Release all keys: held stays for edges r..r+5 and drops at r+6.
    task automatic release_keys(input string tag, input logic [4:0] h1, input logic [4:0] h2);
        if1.inc_key_n = 1'b1;
        if1.dec_key_n = 1'b1;
        if2.inc_key_n = 1'b1;
        if2.dec_key_n = 1'b1;
        tick_n({tag, "_relwait"}, 6, h1, h2);
        tick_n({tag, "_reldone"}, 1, Z, Z);
    endtask

    initial begin
        reset         = 1'b0;
        if1.inc_key_n = 1'b1;
        if1.dec_key_n = 1'b1;
        if2.inc_key_n = 1'b1;
        if2.dec_key_n = 1'b1;
        tick_n("reset", 3, Z, Z);
        reset = 1'b1;
        tick_n("idle", 2, Z, Z);

        // Clean press with auto-repeat: pulses at 6, 16, 19, 22.
        if1.inc_key_n = 1'b0;
        tick_n("clean_debounce", 6, Z, Z);
        tick_n("clean_accept", 1, PI | HI, Z);
        tick_n("clean_delay", 9, HI, Z);
        tick_n("clean_rep1", 1, PI | HI, Z);
        tick_n("clean_gap1", 2, HI, Z);
        tick_n("clean_rep2", 1, PI | HI, Z);
        tick_n("clean_gap2", 2, HI, Z);
        tick_n("clean_rep3", 1, PI | HI, Z);
        release_keys("clean", HI, Z);

        // Bounce: low at 0..2, high at 3, low from 4 -> single pulse at 10.
        if1.inc_key_n = 1'b0;
        tick_n("bounce_low", 3, Z, Z);
        if1.inc_key_n = 1'b1;
        tick_n("bounce_high", 1, Z, Z);
        if1.inc_key_n = 1'b0;
        tick_n("bounce_settle", 6, Z, Z);
        tick_n("bounce_accept", 1, PI | HI, Z);
        release_keys("bounce", HI, Z);

        // Release glitch: HELD re-entered at edge 13, repeat pulse at 23.
        if1.inc_key_n = 1'b0;
        tick_n("glitch_debounce", 6, Z, Z);
        tick_n("glitch_accept", 1, PI | HI, Z);
        tick_n("glitch_hold", 2, HI, Z);
        if1.inc_key_n = 1'b1;
        tick_n("glitch_open", 2, HI, Z);
        if1.inc_key_n = 1'b0;
        tick_n("glitch_redelay", 12, HI, Z);
        tick_n("glitch_rep", 1, PI | HI, Z);
        release_keys("glitch", HI, Z);

        // Simultaneous press: events cancel, conflict for one cycle.
        if1.inc_key_n = 1'b0;
        if1.dec_key_n = 1'b0;
        tick_n("simul_debounce", 6, Z, Z);
        tick_n("simul_conflict", 1, CF | HI | HD, Z);
        release_keys("simul", HI | HD, Z);

        // Staggered press: dec one edge later -> separate pulses, no conflict.
        if1.inc_key_n = 1'b0;
        tick_n("stagger_e0", 1, Z, Z);
        if1.dec_key_n = 1'b0;
        tick_n("stagger_debounce", 5, Z, Z);
        tick_n("stagger_inc", 1, PI | HI, Z);
        tick_n("stagger_dec", 1, PD | HI | HD, Z);
        release_keys("stagger", HI | HD, Z);

        // Reset in REPEAT: outputs clear, new acceptance 6 edges after release of reset.
        if1.inc_key_n = 1'b0;
        tick_n("rstmid_debounce", 6, Z, Z);
        tick_n("rstmid_accept", 1, PI | HI, Z);
        tick_n("rstmid_delay", 9, HI, Z);
        tick_n("rstmid_rep", 1, PI | HI, Z);
        tick_n("rstmid_gap", 1, HI, Z);
        reset = 1'b0;
        tick_n("rstmid_reset", 1, Z, Z);
        reset = 1'b1;
        tick_n("rstmid_redebounce", 6, Z, Z);
        tick_n("rstmid_reaccept", 1, PI | HI, Z);
        release_keys("rstmid", HI, Z);

        // Auto-repeat disabled: 50 held edges give exactly one pulse.
        if2.inc_key_n = 1'b0;
        tick_n("norep_debounce", 6, Z, Z);
        tick_n("norep_accept", 1, Z, PI | HI);
        tick_n("norep_hold", 43, Z, HI);
        release_keys("norep", Z, HI);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 500000, number of consecutive stable synchronized samples required to accept a press or release.
REQ-002 Parameter REPEAT_DELAY, default 25000000, cycles from accepted press to first auto-repeat pulse.
REQ-003 Parameter REPEAT_PERIOD, default 5000000, cycles between subsequent auto-repeat pulses.
REQ-004 Parameter REPEAT_EN, default 1, 1 = auto-repeat enabled, 0 = one pulse per accepted press.
REQ-005 clk  input  1  clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 inc_key_n  input  1  raw increment key, asynchronous, active-low (0 = pressed).
REQ-008 dec_key_n  input  1  raw decrement key, asynchronous, active-low (0 = pressed).
REQ-009 inc_pulse  output  1  registered single-cycle increment event.
REQ-010 dec_pulse  output  1  registered single-cycle decrement event.
REQ-011 inc_held  output  1  registered debounced pressed level, increment key.
REQ-012 dec_held  output  1  registered debounced pressed level, decrement key.
REQ-013 conflict  output  1  registered single-cycle flag, simultaneous inc/dec event suppressed.

Function
REQ-014 Each key SHALL pass through a 2-flop synchronizer before any other logic; downstream logic uses only the second flop output (s).
REQ-015 Each channel SHALL run an independent FSM: IDLE, PRESS_WAIT, HELD, REPEAT, RELEASE_WAIT.
REQ-016 IDLE: s pressed -> PRESS_WAIT, stable counter = 1; otherwise stay.
REQ-017 PRESS_WAIT: s pressed increments counter; s released -> IDLE, counter cleared, no pulse; counter reaching DEBOUNCE_CYCLES -> HELD, counter cleared, one event generated.
REQ-018 With a clean press, the event pulse SHALL appear exactly DEBOUNCE_CYCLES+2 cycles after the first clk edge sampling the pin low, high for exactly one cycle.
REQ-019 HELD: repeat counter increments each cycle; on reaching REPEAT_DELAY with REPEAT_EN=1 -> REPEAT, counter cleared, one event; with REPEAT_EN=0 counter saturates, no event.
REQ-020 REPEAT: repeat counter increments; on reaching REPEAT_PERIOD, counter cleared, one event, stay in REPEAT.
REQ-021 HELD or REPEAT with s released -> RELEASE_WAIT, stable counter = 1, repeat counter cleared.
REQ-022 RELEASE_WAIT: s released increments counter; reaching DEBOUNCE_CYCLES -> IDLE, no event; s pressed before that -> HELD, counters cleared, no event.
REQ-023 *_held SHALL be 1 in HELD, REPEAT, RELEASE_WAIT and 0 in IDLE, PRESS_WAIT.
REQ-024 All counters SHALL be sized $clog2(max parameter + 1) bits, never wrap, and compare with equality to the parameter.
REQ-025 If both channels generate an event in the same cycle, inc_pulse and dec_pulse SHALL both be 0 that cycle and conflict SHALL be 1 for that cycle; FSMs advance normally.
REQ-026 An event on one channel only SHALL drive only its own pulse; conflict stays 0.
REQ-027 Pulses SHALL never be high on two consecutive cycles per channel (REPEAT_PERIOD >= 2 required; REPEAT_PERIOD < 2 is illegal).

Reset
REQ-028 On a clk edge with reset = 0: both FSMs -> IDLE, all counters 0, synchronizer flops -> 1 (released), all outputs 0.
REQ-029 Reset mid-press (any state) SHALL drop *_held and suppress pulses from the next cycle; a key still held after reset release SHALL need a full DEBOUNCE_CYCLES press acceptance before any pulse.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, REPEAT_EN=1)
REQ-030 Clean press: inc_key_n low at edge 0 and held -> inc_pulse high at edge 6 only, inc_held high from edge 6, next pulses at edges 16, 19, 22.
REQ-031 Bounce: inc_key_n low 3 cycles, high 1, low thereafter -> no pulse in the first bounce window; single pulse 6 cycles after the last falling edge.
REQ-032 Release glitch: hold, release for 2 cycles, press again -> inc_held stays 1, no extra pulse, repeat timing restarts (pulse 10 cycles after re-entry to HELD).
REQ-033 Simultaneous: both keys low at the same edge -> at edge 6 inc_pulse=0, dec_pulse=0, conflict=1; dec pressed 1 cycle later -> inc_pulse at 6, dec_pulse at 7, conflict 0.
REQ-034 Reset mid-repeat: hold inc into REPEAT, assert reset for 1 cycle -> all outputs 0 next cycle; key still low -> next inc_pulse 6 cycles after reset deassertion.
REQ-035 REPEAT_EN=0: hold inc for 50 cycles -> exactly one inc_pulse; release 4 cycles -> inc_held falls, no pulse.
